spi_cmd_decoder: RTL and testbench

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

---
 rtl/spi_cmd_decoder_if.sv | 27 ++
 rtl/spi_cmd_decoder.sv | 157 +++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_decoder_if.sv
// Bundle of the SPI-slave parallel side and the register-bus side of the
// command decoder. The decoder drives the register bus and the transmit byte,
// so it uses the master modport; the SPI slave / register file use slave.
interface spi_cmd_decoder_if #(
    parameter int WIDTH = 8
);
    logic             cs;
    logic [WIDTH-1:0] rx_byte;
    logic             rx_strobe;
    logic [WIDTH-1:0] tx_byte;
    logic [WIDTH-2:0] reg_addr;
    logic [WIDTH-1:0] reg_wdata;
    logic             reg_wr;
    logic             reg_rd;
    logic [WIDTH-1:0] reg_rdata;
    logic             busy;

    modport master (
        input  cs, rx_byte, rx_strobe, reg_rdata,
        output tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );

    modport slave (
        output cs, rx_byte, rx_strobe, reg_rdata,
        input  tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns a chip-select framed byte stream into register
// reads and writes. The first byte of a frame is the command (MSB = read,
// remaining bits = start address); following bytes are write data or, for
// reads, dummy bytes that advance the address and prefetch the next tx byte.
module spi_cmd_decoder #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    spi_cmd_decoder_if.master bus
);
    localparam int AW = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WRITE,
        READ
    } state_t;

    state_t state, state_next;

    logic cs_meta, cs_sync, cs_prev;
    logic strobe_meta, strobe_sync, strobe_prev;
    logic [1:0] sync_valid;

    logic [AW-1:0]    addr_q, addr_next;
    logic [WIDTH-1:0] wdata_q, wdata_next;
    logic [WIDTH-1:0] tx_q, tx_next;
    logic             wr_q, wr_next;
    logic             rd_q, rd_next;
    logic             advance_q, advance_next;

    logic byte_event;
    logic cs_fall;
    logic cs_rise;

    // cs_prev only follows the synchronizer once real samples have reached
    // its output, so a reset released in the middle of a frame (cs already
    // low) is never mistaken for a fresh cs falling edge.
    assign byte_event = strobe_sync & ~strobe_prev & ~cs_sync;
    assign cs_fall    = cs_prev & ~cs_sync;
    assign cs_rise    = ~cs_prev & cs_sync;

    // Bring cs and rx_strobe into the clk domain and keep one-cycle-old copies for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta     <= 1'b1;
            cs_sync     <= 1'b1;
            strobe_meta <= 1'b0;
            strobe_sync <= 1'b0;
            strobe_prev <= 1'b0;
            cs_prev     <= 1'b0;
            sync_valid  <= 2'b00;
        end else begin
            cs_meta     <= bus.cs;
            cs_sync     <= cs_meta;
            strobe_meta <= bus.rx_strobe;
            strobe_sync <= strobe_meta;
            strobe_prev <= strobe_sync;
            sync_valid  <= {sync_valid[0], 1'b1};
            cs_prev     <= sync_valid[1] & cs_sync;
        end
    end

    // Frame state and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_q      <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            advance_q <= 1'b0;
        end else begin
            state     <= state_next;
            addr_q    <= addr_next;
            wdata_q   <= wdata_next;
            tx_q      <= tx_next;
            wr_q      <= wr_next;
            rd_q      <= rd_next;
            advance_q <= advance_next;
        end
    end

    // Next-state and next-output decode; a cs rise wins over any strobe in the same cycle
    always_comb begin
        state_next   = state;
        addr_next    = addr_q;
        wdata_next   = wdata_q;
        tx_next      = tx_q;
        wr_next      = 1'b0;
        rd_next      = 1'b0;
        advance_next = advance_q;

        if (rd_q) begin
            tx_next = bus.reg_rdata;
        end

        if (state != IDLE && cs_rise) begin
            state_next = IDLE;
            tx_next    = tx_q;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_next   = CMD;
                        tx_next      = '0;
                        advance_next = 1'b0;
                    end
                end
                CMD: begin
                    if (byte_event) begin
                        addr_next = bus.rx_byte[AW-1:0];
                        if (bus.rx_byte[WIDTH-1]) begin
                            state_next = READ;
                            rd_next    = 1'b1;
                        end else begin
                            state_next = WRITE;
                        end
                    end
                end
                WRITE: begin
                    // The address steps forward only when another data byte
                    // arrives, so after the frame reg_addr names the last
                    // register actually written.
                    if (byte_event) begin
                        wdata_next   = bus.rx_byte;
                        wr_next      = 1'b1;
                        advance_next = 1'b1;
                        if (advance_q) begin
                            addr_next = addr_q + AW'(1);
                        end
                    end
                end
                READ: begin
                    if (byte_event) begin
                        addr_next = addr_q + AW'(1);
                        rd_next   = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.tx_byte   = tx_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_rd    = rd_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Testbench for spi_cmd_decoder: table of directed frames, randomized frames
// against a transaction-level reference model, and hand-written corner cases
// (latency, strobes with cs high, reset mid-frame, cs rising with a strobe).
module tb_spi_cmd_decoder;

    logic clk = 1'b0;
    logic rst_n;

    spi_cmd_decoder_if #(.WIDTH(8)) bus ();

    spi_cmd_decoder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file model: read data is the address plus 0x10
    assign bus.reg_rdata = {1'b0, bus.reg_addr} + 8'h10;

    // 100 MHz system clock
    always #5 clk = ~clk;

    typedef struct {
        int          nbytes;
        logic [31:0] bytes;
        int          exp_wr;
        int          exp_rd;
        logic [6:0]  exp_first;
        logic [6:0]  exp_addr;
        logic [7:0]  exp_tx;
        logic [7:0]  exp_lastw;
    } vec_t;

    vec_t vecs[7];

    int errors = 0;
    int checks = 0;

    logic [7:0] frame_bytes[$];
    logic [6:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];
    logic [6:0] rd_addr_log[$];
    int         exp_wr_addr[$];
    int         exp_wr_data[$];
    int         exp_rd_addr[$];
    int         exp_addr;
    int         exp_tx;
    logic       both_seen = 1'b0;

    // Record every register access seen on the bus, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.reg_wr) begin
                wr_addr_log.push_back(bus.reg_addr);
                wr_data_log.push_back(bus.reg_wdata);
            end
            if (bus.reg_rd) begin
                rd_addr_log.push_back(bus.reg_addr);
            end
            if (bus.reg_wr && bus.reg_rd) begin
                both_seen = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic clearLogs();
        @(posedge clk);
        #1;
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_byte   = b;
        bus.rx_strobe = 1'b1;
        repeat (3) @(negedge clk);
        bus.rx_strobe = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Drive one complete cs-framed transfer of frame_bytes
    task automatic applyStimulus();
        clearLogs();
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (4) @(negedge clk);
        foreach (frame_bytes[k]) sendByte(frame_bytes[k]);
        @(negedge clk);
        bus.cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Reference model: list of accesses implied by a frame, derived from the
    // command byte and the byte count alone
    task automatic buildExpect();
        logic [7:0] cmd;
        int base;
        int n;
        cmd = frame_bytes[0];
        base = int'(cmd[6:0]);
        n = frame_bytes.size() - 1;
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_rd_addr.delete();
        if (cmd[7]) begin
            for (int k = 0; k <= n; k++) exp_rd_addr.push_back((base + k) % 128);
            exp_addr = (base + n) % 128;
            exp_tx   = (exp_addr + 16) % 256;
        end else begin
            for (int k = 0; k < n; k++) begin
                exp_wr_addr.push_back((base + k) % 128);
                exp_wr_data.push_back(int'(frame_bytes[k + 1]));
            end
            exp_addr = (n > 0) ? (base + n - 1) % 128 : base;
            exp_tx   = 0;
        end
    endtask

    task automatic checkAgainstModel(input int idx);
        checkOutput($sformatf("rnd%0d_wr_count", idx), 32'(wr_addr_log.size()), 32'(exp_wr_addr.size()));
        checkOutput($sformatf("rnd%0d_rd_count", idx), 32'(rd_addr_log.size()), 32'(exp_rd_addr.size()));
        for (int k = 0; k < exp_wr_addr.size(); k++) begin
            checkOutput($sformatf("rnd%0d_wr%0d_addr", idx, k),
                        (k < wr_addr_log.size()) ? 32'(wr_addr_log[k]) : 32'hxxxxxxxx, 32'(exp_wr_addr[k]));
            checkOutput($sformatf("rnd%0d_wr%0d_data", idx, k),
                        (k < wr_data_log.size()) ? 32'(wr_data_log[k]) : 32'hxxxxxxxx, 32'(exp_wr_data[k]));
        end
        for (int k = 0; k < exp_rd_addr.size(); k++) begin
            checkOutput($sformatf("rnd%0d_rd%0d_addr", idx, k),
                        (k < rd_addr_log.size()) ? 32'(rd_addr_log[k]) : 32'hxxxxxxxx, 32'(exp_rd_addr[k]));
        end
        checkOutput($sformatf("rnd%0d_reg_addr", idx), 32'(bus.reg_addr), 32'(exp_addr));
        checkOutput($sformatf("rnd%0d_tx_byte", idx), 32'(bus.tx_byte), 32'(exp_tx));
        checkOutput($sformatf("rnd%0d_busy", idx), 32'(bus.busy), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tx_byte"}, 32'(bus.tx_byte), 32'd0);
        checkOutput({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'd0);
        checkOutput({tag, "_reg_wdata"}, 32'(bus.reg_wdata), 32'd0);
        checkOutput({tag, "_reg_wr"}, 32'(bus.reg_wr), 32'd0);
        checkOutput({tag, "_reg_rd"}, 32'(bus.reg_rd), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Latency of a read: tx_byte must reach the expected value within 5 clocks of the strobe
    task automatic readByteWithLatency(input logic [7:0] b, input logic [7:0] expect_tx, input string name);
        logic found;
        found = 1'b0;
        @(negedge clk);
        bus.rx_byte   = b;
        bus.rx_strobe = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            if (!found && bus.tx_byte == expect_tx) found = 1'b1;
        end
        checkOutput(name, 32'(found), 32'd1);
        @(negedge clk);
        bus.rx_strobe = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [31:0] packed_bytes;

        vecs[0] = '{3, 32'h0055AA05, 2, 0, 7'h05, 7'h06, 8'h00, 8'h55};
        vecs[1] = '{2, 32'h00003C83, 0, 2, 7'h03, 7'h04, 8'h14, 8'h00};
        vecs[2] = '{3, 32'h0022117F, 2, 0, 7'h7F, 7'h00, 8'h00, 8'h22};
        vecs[3] = '{1, 32'h00000081, 0, 1, 7'h01, 7'h01, 8'h11, 8'h00};
        vecs[4] = '{4, 32'h03020120, 3, 0, 7'h20, 7'h22, 8'h00, 8'h03};
        vecs[5] = '{3, 32'h000000FF, 0, 3, 7'h7F, 7'h01, 8'h11, 8'h00};
        vecs[6] = '{1, 32'h00000010, 0, 0, 7'h00, 7'h10, 8'h00, 8'h00};

        rst_n         = 1'b0;
        bus.cs        = 1'b1;
        bus.rx_strobe = 1'b0;
        bus.rx_byte   = 8'h00;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] directed frame table");
        for (int v = 0; v < 7; v++) begin
            frame_bytes.delete();
            packed_bytes = vecs[v].bytes;
            for (int k = 0; k < vecs[v].nbytes; k++) frame_bytes.push_back(packed_bytes[8*k +: 8]);
            applyStimulus();
            checkOutput($sformatf("vec%0d_wr_count", v), 32'(wr_addr_log.size()), 32'(vecs[v].exp_wr));
            checkOutput($sformatf("vec%0d_rd_count", v), 32'(rd_addr_log.size()), 32'(vecs[v].exp_rd));
            checkOutput($sformatf("vec%0d_reg_addr", v), 32'(bus.reg_addr), 32'(vecs[v].exp_addr));
            checkOutput($sformatf("vec%0d_tx_byte", v), 32'(bus.tx_byte), 32'(vecs[v].exp_tx));
            checkOutput($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'd0);
            if (vecs[v].exp_wr > 0) begin
                checkOutput($sformatf("vec%0d_first_wr_addr", v),
                            (wr_addr_log.size() > 0) ? 32'(wr_addr_log[0]) : 32'hxxxxxxxx, 32'(vecs[v].exp_first));
                checkOutput($sformatf("vec%0d_last_wdata", v), 32'(bus.reg_wdata), 32'(vecs[v].exp_lastw));
            end
            if (vecs[v].exp_rd > 0) begin
                checkOutput($sformatf("vec%0d_first_rd_addr", v),
                            (rd_addr_log.size() > 0) ? 32'(rd_addr_log[0]) : 32'hxxxxxxxx, 32'(vecs[v].exp_first));
            end
        end

        $display("[TB] randomized frames");
        for (int r = 0; r < 20; r++) begin
            int n;
            frame_bytes.delete();
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) frame_bytes.push_back(8'($urandom_range(0, 255)));
            buildExpect();
            applyStimulus();
            checkAgainstModel(r);
        end

        $display("[TB] read latency");
        clearLogs();
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (4) @(negedge clk);
        readByteWithLatency(8'h83, 8'h13, "latency_cmd_tx_13");
        readByteWithLatency(8'h00, 8'h14, "latency_next_tx_14");
        @(negedge clk);
        bus.cs = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("latency_rd_count", 32'(rd_addr_log.size()), 32'd2);
        checkOutput("latency_rd0_addr", (rd_addr_log.size() > 0) ? 32'(rd_addr_log[0]) : 32'hxxxxxxxx, 32'h03);
        checkOutput("latency_rd1_addr", (rd_addr_log.size() > 1) ? 32'(rd_addr_log[1]) : 32'hxxxxxxxx, 32'h04);

        $display("[TB] strobes with cs high");
        clearLogs();
        sendByte(8'h05);
        sendByte(8'h83);
        sendByte(8'hAA);
        checkOutput("cs_high_wr_count", 32'(wr_addr_log.size()), 32'd0);
        checkOutput("cs_high_rd_count", 32'(rd_addr_log.size()), 32'd0);
        checkOutput("cs_high_busy", 32'(bus.busy), 32'd0);

        $display("[TB] reset in the middle of a write frame");
        clearLogs();
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (4) @(negedge clk);
        sendByte(8'h40);
        sendByte(8'h12);
        checkOutput("midrst_pre_wr_count", 32'(wr_addr_log.size()), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkAllZero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clearLogs();
        sendByte(8'h34);
        sendByte(8'h56);
        checkOutput("midrst_post_wr_count", 32'(wr_addr_log.size()), 32'd0);
        checkOutput("midrst_post_rd_count", 32'(rd_addr_log.size()), 32'd0);
        checkOutput("midrst_post_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.cs = 1'b1;
        repeat (6) @(negedge clk);
        frame_bytes.delete();
        frame_bytes.push_back(8'h02);
        frame_bytes.push_back(8'h99);
        buildExpect();
        applyStimulus();
        checkAgainstModel(100);

        $display("[TB] cs rising together with a strobe");
        clearLogs();
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (4) @(negedge clk);
        sendByte(8'h30);
        @(negedge clk);
        bus.rx_byte   = 8'h5A;
        bus.rx_strobe = 1'b1;
        bus.cs        = 1'b1;
        repeat (6) @(negedge clk);
        bus.rx_strobe = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("csrise_wr_count", 32'(wr_addr_log.size()), 32'd0);
        checkOutput("csrise_busy", 32'(bus.busy), 32'd0);
        checkOutput("csrise_reg_addr", 32'(bus.reg_addr), 32'h30);
        checkOutput("csrise_reg_wdata", 32'(bus.reg_wdata), 32'h99);

        checkOutput("rd_wr_exclusive", 32'(both_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
